// File: rtl/pulse_event_fifo_pkg.sv
// Shared constants and width helpers for the pulse event FIFO.
package pulse_event_fifo_pkg;

    localparam logic [7:0] DROP_SAT = 8'hFF;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    // Pointer carries one extra MSB so full and empty are distinguishable.
    function automatic int ptr_w(input int depth);
        return clog2(depth) + 1;
    endfunction

    function automatic int entry_w(input int width, input int ts_width);
        return width + ts_width;
    endfunction

endpackage

// File: rtl/pulse_event_fifo_if.sv
// Event handshake toward the downstream consumer (register block or logger).
interface pulse_event_fifo_if #(
    parameter int Width   = 1,
    parameter int TsWidth = 16
) ();
    logic               Evt_Valid;
    logic               Evt_Ready;
    logic [Width-1:0]   Evt_Data;
    logic [TsWidth-1:0] Evt_Ts;

    modport master (output Evt_Valid, Evt_Data, Evt_Ts, input Evt_Ready);
    modport slave  (input Evt_Valid, Evt_Data, Evt_Ts, output Evt_Ready);
endinterface

// File: rtl/pulse_event_fifo_core.sv
// Plain synchronous FIFO: storage, pointers and occupancy; the caller decides what to drop.
module sync_fifo_core
    import pulse_event_fifo_pkg::*;
#(
    parameter int EntryW = 17,
    parameter int Depth  = 8,
    localparam int PtrW  = ptr_w(Depth),
    localparam int AddrW = PtrW - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [EntryW-1:0] wdata,
    output logic [EntryW-1:0] rdata,
    output logic [PtrW-1:0]   count,
    output logic              full,
    output logic              empty
);

    logic [Depth-1:0][EntryW-1:0] mem;
    logic [PtrW-1:0]              wr_ptr, rd_ptr;
    logic                         rd_en;

    assign rd_en = pop && !empty;
    assign full  = (count == PtrW'(Depth));
    assign empty = (count == '0);
    assign rdata = mem[rd_ptr[AddrW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AddrW-1:0]] <= wdata;
                wr_ptr                 <= wr_ptr + PtrW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + PtrW'(1);
            case ({push, rd_en})
                2'b10:   count <= count + PtrW'(1);
                2'b01:   count <= count - PtrW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pulse_event_fifo.sv
// Timestamps each non-zero pulse vector and queues it; drops on full without stalling the producer.
module pulse_event_fifo
    import pulse_event_fifo_pkg::*;
#(
    parameter int Width   = 1,
    parameter int Depth   = 8,
    parameter int TsWidth = 16,
    localparam int PtrW   = ptr_w(Depth),
    localparam int EntryW = entry_w(Width, TsWidth)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [Width-1:0]   Pulse_In,
    input  logic               Ts_Clear,
    pulse_event_fifo_if.master evt,
    output logic [PtrW-1:0]    Count,
    output logic               Overflow,
    input  logic               Overflow_Clr,
    output logic [7:0]         Drop_Cnt
);

    logic [TsWidth-1:0] ts;
    logic [EntryW-1:0]  rdata;
    logic               req, pop, push, drop, full, empty;

    assign req  = |Pulse_In;
    assign pop  = evt.Evt_Valid && evt.Evt_Ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push = req && (!full || pop);
    assign drop = req && full && !pop;

    assign evt.Evt_Valid              = !empty;
    assign {evt.Evt_Data, evt.Evt_Ts} = rdata;

    sync_fifo_core #(.EntryW(EntryW), .Depth(Depth)) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({Pulse_In, ts}),
        .rdata (rdata),
        .count (Count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ts <= '0;
        else if (Ts_Clear) ts <= '0;
        else ts <= ts + TsWidth'(1);
    end

    // A drop coinciding with a clear restarts the record at one drop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Overflow <= 1'b0;
            Drop_Cnt <= '0;
        end else if (drop) begin
            Overflow <= 1'b1;
            if (Overflow_Clr)            Drop_Cnt <= 8'd1;
            else if (Drop_Cnt != DROP_SAT) Drop_Cnt <= Drop_Cnt + 8'd1;
        end else if (Overflow_Clr) begin
            Overflow <= 1'b0;
            Drop_Cnt <= '0;
        end
    end

endmodule

// File: tb/tb_pulse_event_fifo.sv
// Scenario bench for pulse_event_fifo with a queue scoreboard checking every pop.
module tb_pulse_event_fifo;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int TW = 4;
    localparam int PW = 3;

    logic          clk = 0;
    logic          rst_n = 0;
    logic [W-1:0]  Pulse_In = '0;
    logic          Ts_Clear = 0;
    logic          Overflow_Clr = 0;
    logic [PW-1:0] Count;
    logic          Overflow;
    logic [7:0]    Drop_Cnt;

    int errors = 0;
    int checks = 0;

    logic [W+TW-1:0] q[$];
    logic [TW-1:0]   mts = '0;

    pulse_event_fifo_if #(.Width(W), .TsWidth(TW)) evt ();

    pulse_event_fifo #(.Width(W), .Depth(D), .TsWidth(TW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .Pulse_In     (Pulse_In),
        .Ts_Clear     (Ts_Clear),
        .evt          (evt),
        .Count        (Count),
        .Overflow     (Overflow),
        .Overflow_Clr (Overflow_Clr),
        .Drop_Cnt     (Drop_Cnt)
    );

    always #5 clk = ~clk;

    initial evt.Evt_Ready = 1'b0;

    // Scoreboard: compare state for this cycle, then apply the cycle's push/pop to the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            mts = '0;
        end else begin
            checks++;
            if (evt.Evt_Valid !== (q.size() != 0)) begin
                errors++;
                $display("FAIL sb_valid: got %b expected %b", evt.Evt_Valid, q.size() != 0);
            end
            checks++;
            if (Count !== PW'(q.size())) begin
                errors++;
                $display("FAIL sb_count: got %0d expected %0d", Count, q.size());
            end
            if (evt.Evt_Valid === 1'b1 && evt.Evt_Ready && q.size() != 0) begin
                checks++;
                if ({evt.Evt_Data, evt.Evt_Ts} !== q[0]) begin
                    errors++;
                    $display("FAIL sb_pop: got data=%b ts=%0d expected data=%b ts=%0d",
                             evt.Evt_Data, evt.Evt_Ts, q[0][W+TW-1:TW], q[0][TW-1:0]);
                end
                void'(q.pop_front());
            end
            if (Pulse_In != '0 && q.size() < D) q.push_back({Pulse_In, mts});
            mts = Ts_Clear ? '0 : mts + TW'(1);
        end
    end

    // Inputs for the cycle starting at this edge; outputs then show that cycle's state.
    task automatic drive(input logic [W-1:0] p, input logic rdy, input logic clr = 0,
                         input logic oclr = 0);
        @(posedge clk);
        #1;
        Pulse_In      = p;
        evt.Evt_Ready = rdy;
        Ts_Clear      = clr;
        Overflow_Clr  = oclr;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (evt.Evt_Valid !== 1'b0 || Count !== '0 || Overflow !== 1'b0 || Drop_Cnt !== 8'd0 ||
            evt.Evt_Data !== '0 || evt.Evt_Ts !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b c=%0d ovf=%b drop=%0d d=%b ts=%0d required all 0",
                     evt.Evt_Valid, Count, Overflow, Drop_Cnt, evt.Evt_Data, evt.Evt_Ts);
        end
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1;
    endtask

    task automatic test_single_push();
        drive('0, 0, 1);
        for (int i = 0; i < 5; i++) drive('0, 0);
        drive(4'b0001, 0);
        drive('0, 0);
        checks++;
        if (evt.Evt_Valid !== 1'b1 || evt.Evt_Data !== 4'b0001 || evt.Evt_Ts !== 4'd5 || Count !== 3'd1) begin
            errors++;
            $display("FAIL single_push: got v=%b d=%b ts=%0d c=%0d required v=1 d=0001 ts=5 c=1",
                     evt.Evt_Valid, evt.Evt_Data, evt.Evt_Ts, Count);
        end
    endtask

    task automatic test_stream();
        drive('0, 1, 1);
        drive('0, 1);
        drive('0, 1);
        drive(4'b0010, 1);
        drive(4'b0100, 1);
        drive(4'b1000, 1);
        drive('0, 1);
        checks++;
        if (evt.Evt_Valid !== 1'b1 || evt.Evt_Ts !== 4'd4 || evt.Evt_Data !== 4'b1000 || Count !== 3'd1) begin
            errors++;
            $display("FAIL stream_last: got v=%b d=%b ts=%0d c=%0d required v=1 d=1000 ts=4 c=1",
                     evt.Evt_Valid, evt.Evt_Data, evt.Evt_Ts, Count);
        end
        drive('0, 1);
        checks++;
        if (evt.Evt_Valid !== 1'b0 || Count !== 3'd0) begin
            errors++;
            $display("FAIL stream_drain: got v=%b c=%0d required v=0 c=0", evt.Evt_Valid, Count);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) drive(W'(i + 1), 0);
        drive(4'b1111, 0);
        checks++;
        if (Count !== 3'd4 || Overflow !== 1'b0 || Drop_Cnt !== 8'd0) begin
            errors++;
            $display("FAIL full_no_ovf: got c=%0d ovf=%b drop=%0d required c=4 ovf=0 drop=0",
                     Count, Overflow, Drop_Cnt);
        end
        drive(4'b1111, 0);
        drive(4'b1111, 0);
        drive('0, 0);
        checks++;
        if (Count !== 3'd4 || Overflow !== 1'b1 || Drop_Cnt !== 8'd3) begin
            errors++;
            $display("FAIL overflow: got c=%0d ovf=%b drop=%0d required c=4 ovf=1 drop=3",
                     Count, Overflow, Drop_Cnt);
        end
    endtask

    task automatic test_full_push_pop();
        logic [TW-1:0] exp_ts;
        drive(4'b1010, 1);
        exp_ts = mts;
        drive('0, 1);
        checks++;
        if (Count !== 3'd4 || Drop_Cnt !== 8'd3) begin
            errors++;
            $display("FAIL full_push_pop: got c=%0d drop=%0d required c=4 drop=3", Count, Drop_Cnt);
        end
        drive('0, 1);
        drive('0, 1);
        drive('0, 0);
        checks++;
        if (evt.Evt_Data !== 4'b1010 || evt.Evt_Ts !== exp_ts || Count !== 3'd1) begin
            errors++;
            $display("FAIL late_entry: got d=%b ts=%0d c=%0d required d=1010 ts=%0d c=1",
                     evt.Evt_Data, evt.Evt_Ts, Count, exp_ts);
        end
        drive('0, 1);
        drive('0, 0);
    endtask

    task automatic test_overflow_clr();
        for (int i = 0; i < 4; i++) drive(4'b0110, 0);
        drive(4'b0001, 0, 0, 1);
        drive('0, 0, 0, 1);
        checks++;
        if (Overflow !== 1'b1 || Drop_Cnt !== 8'd1) begin
            errors++;
            $display("FAIL clr_with_drop: got ovf=%b drop=%0d required ovf=1 drop=1", Overflow, Drop_Cnt);
        end
        drive('0, 0);
        checks++;
        if (Overflow !== 1'b0 || Drop_Cnt !== 8'd0) begin
            errors++;
            $display("FAIL clr_alone: got ovf=%b drop=%0d required ovf=0 drop=0", Overflow, Drop_Cnt);
        end
        for (int i = 0; i < 4; i++) drive('0, 1);
        drive('0, 0);
    endtask

    task automatic test_wrap_and_reset();
        drive('0, 0, 1);
        for (int i = 0; i < 15; i++) drive('0, 0);
        drive(4'b0001, 0);
        drive(4'b0010, 0);
        drive('0, 1);
        checks++;
        if (evt.Evt_Ts !== 4'd15 || Count !== 3'd2) begin
            errors++;
            $display("FAIL wrap_hi: got ts=%0d c=%0d required ts=15 c=2", evt.Evt_Ts, Count);
        end
        drive('0, 0);
        checks++;
        if (evt.Evt_Ts !== 4'd0 || evt.Evt_Data !== 4'b0010 || Count !== 3'd1) begin
            errors++;
            $display("FAIL wrap_lo: got ts=%0d d=%b c=%0d required ts=0 d=0010 c=1",
                     evt.Evt_Ts, evt.Evt_Data, Count);
        end
        drive(4'b1111, 0);
        drive('0, 0);
        rst_n = 0;
        #1;
        checks++;
        if (evt.Evt_Valid !== 1'b0 || Count !== '0 || evt.Evt_Data !== '0 || evt.Evt_Ts !== '0) begin
            errors++;
            $display("FAIL async_reset: got v=%b c=%0d d=%b ts=%0d required all 0",
                     evt.Evt_Valid, Count, evt.Evt_Data, evt.Evt_Ts);
        end
        drive('0, 0);
        @(posedge clk);
        #1 rst_n = 1;
        drive('0, 0);
        checks++;
        if (evt.Evt_Valid !== 1'b0 || Count !== '0) begin
            errors++;
            $display("FAIL post_reset: got v=%b c=%0d required v=0 c=0", evt.Evt_Valid, Count);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_push();
        test_stream();
        test_overflow();
        test_full_push_pop();
        test_overflow_clr();
        test_wrap_and_reset();
        drive('0, 0);
        drive('0, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_event_fifo.md
Name: pulse_event_fifo

Overview:
- Consumes the per-bit, single-cycle leading-edge pulse vector produced by the leading-edge retiming stage.
- Each cycle with any pulse bit set is recorded as one event: the pulse vector plus a free-running timestamp.
- Events are queued in a FIFO and handed to a downstream consumer (CPU register interface or logger) over a valid/ready handshake.
- Overflow is detected and reported without ever stalling the producer.

Parameters:
- Width, 1: pulse vector width; must match the upstream retimer.
- Depth, 8: FIFO entries; power of 2, >= 2.
- TsWidth, 16: timestamp counter width, >= 4.

Ports:
- clk  input  1  single clock; all logic rising-edge.
- rst_n  input  1  asynchronous assert, active-low reset; deassertion is synchronous to clk externally.
- Pulse_In  input  Width  single-cycle leading-edge pulses, already synchronous to clk.
- Ts_Clear  input  1  synchronous timestamp counter clear.
- Evt_Valid  output  1  head entry available.
- Evt_Ready  input  1  consumer accepts head entry.
- Evt_Data  output  Width  pulse vector of head entry.
- Evt_Ts  output  TsWidth  timestamp of head entry.
- Count  output  clog2(Depth)+1  entries currently held.
- Overflow  output  1  sticky: at least one event was dropped.
- Overflow_Clr  input  1  clears Overflow and Drop_Cnt.
- Drop_Cnt  output  8  saturating count of dropped events.

Behaviour:
Reset:
- rst_n low asynchronously forces: read/write pointers = 0, Count = 0, Evt_Valid = 0, timestamp = 0, Overflow = 0, Drop_Cnt = 0.
- Evt_Data and Evt_Ts read 0 while reset is asserted (storage is reset).
- Reset asserted mid-operation discards all queued events; there is no partial state.

Timestamp counter:
- Increments every cycle and wraps from 2^TsWidth-1 to 0.
- Ts_Clear in cycle N gives a timestamp of 0 in cycle N+1.

Push:
- Push request in cycle N when Pulse_In != 0.
- The entry is {Pulse_In, timestamp value during cycle N}.
- Written at the end of cycle N; Evt_Valid rises in cycle N+1, so latency is 1 cycle.
- There is no same-cycle bypass, even when the FIFO is empty.
- Multiple pulse bits set in the same cycle produce one entry with all of those bits set.

Pop:
- Occurs when Evt_Valid & Evt_Ready.
- Evt_Valid = (Count != 0).
- Evt_Data and Evt_Ts are driven from storage at the read pointer and are stable while Evt_Valid is high and Evt_Ready is low.
- Evt_Ready while empty has no effect.

Pointers and Count:
- Pointers are clog2(Depth)+1 bits; the MSB distinguishes full from empty, and pointers wrap naturally.
- Count = wr_ptr - rd_ptr, registered.
- Push only: +1. Pop only: -1. Both: unchanged.

Full:
- Full (Count == Depth) with a push request and no pop in the same cycle:
  - the event is dropped and storage is unchanged;
  - Overflow is set in cycle N+1;
  - Drop_Cnt increments, saturating at 255.
- Full with push and pop in the same cycle: both succeed and nothing is dropped.

Overflow_Clr:
- Clears Overflow and Drop_Cnt next cycle.
- If a drop occurs in the same cycle as Overflow_Clr, the set wins: Overflow = 1 and Drop_Cnt = 1.

Decomposition:
- Package pulse_event_fifo_pkg holds:
  - a clog2 constant function;
  - derived widths: PtrW = clog2(Depth)+1, EntryW = Width+TsWidth;
  - the Drop_Cnt saturation constant 8'hFF.
- Sub-module sync_fifo_core (parameters EntryW, Depth):
  - contains storage, pointers, Count, full/empty, push/pop;
  - has no drop policy.
- The top level contains the timestamp counter, push-request generation, drop/overflow logic and entry packing.

Test Plan:
1. Width=4, Depth=4. Reset, Ts_Clear, then Pulse_In=4'b0001 at ts=5, Evt_Ready=0 -> next cycle Evt_Valid=1, Evt_Data=4'b0001, Evt_Ts=5, Count=1.
2. Pulses at ts=2,3,4 with Evt_Ready=1 continuously -> entries popped in order (2,3,4) with the data intact; Count returns to 0; Evt_Valid falls one cycle after the last pop.
3. Fill 4 entries, Evt_Ready=0, then 3 further pulses -> Count stays 4, Overflow=1, Drop_Cnt=3; the queued timestamps are the original 4.
4. Full, then push and pop in the same cycle -> Count stays 4, Drop_Cnt unchanged, and the new entry appears 4 pops later.
5. Overflow_Clr coinciding with a drop -> Overflow=1, Drop_Cnt=1. Overflow_Clr alone next cycle -> both 0.
6. TsWidth=4: pulse at ts=15 then at ts=0 (wrap) -> Evt_Ts=15 then 0. rst_n pulsed low mid-queue -> Evt_Valid=0 and Count=0 immediately, without waiting for a clock edge.
